// File: rtl/credit_stream_tx_if.sv
// ready_valid_i: generic ready/valid stream interface.
//
// Parameters:
//   data_t  payload type carried on data
//
// Signals:
//   valid  producer has a beat on data this cycle
//   ready  consumer accepts the beat this cycle
//   data   payload
//
// Modports:
//   s  sink side (consumes valid/data, drives ready)
//   m  source side (drives valid/data, consumes ready)
interface ready_valid_i #(
  parameter type data_t = logic [7:0]
) ();
  logic  valid;
  logic  ready;
  data_t data;

  modport s (input valid, input data, output ready);
  modport m (output valid, output data, input ready);
endinterface

// File: rtl/credit_stream_tx.sv
// credit_stream_tx: transmit end of a credit-flow-controlled stream link.
//
// Accepts a ready/valid stream and forwards each accepted beat, one cycle later,
// as a non-stallable valid/data strobe toward a remote buffer of NUM_CREDITS
// entries. One credit is consumed per beat; the receiver hands credits back on
// credit_incr as it drains.
//
// Parameters:
//   data_t       payload type
//   NUM_CREDITS  receiver buffer depth and initial credit count (>= 1)
//
// Ports:
//   clk            clock, posedge
//   rst_n          asynchronous active-low reset
//   in             upstream stream (ready_valid_i sink modport)
//   out_valid      one-cycle beat strobe toward the link
//   out_data       payload of the beat, valid while out_valid=1
//   credit_incr    credits returned by the receiver this cycle
//   credit_clr     synchronous re-init of credits, error flag and statistics
//   credits_avail  current credit count
//   credit_err     sticky flag: returned credits overflowed NUM_CREDITS
//   stall_cnt      cycles with in.valid && !in.ready (statistics build only)
//   beat_cnt       beats transmitted (statistics build only)
//
// Build option:
//   CREDIT_STREAM_TX_STATS_EN  when defined, stall_cnt/beat_cnt are saturating
//                              counters; otherwise both are tied to zero.
module credit_stream_tx #(
  parameter type data_t      = logic [7:0],
  parameter int  NUM_CREDITS = 8,
  localparam int CW          = $clog2(NUM_CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ready_valid_i.s                  in,
  output logic                     out_valid,
  output logic [$bits(data_t)-1:0] out_data,
  input  logic [CW-1:0]            credit_incr,
  input  logic                     credit_clr,
  output logic [CW-1:0]            credits_avail,
  output logic                     credit_err,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              beat_cnt
);

  localparam logic [CW:0]   FULL_EXT = (CW + 1)'(NUM_CREDITS);
  localparam logic [CW-1:0] FULL     = CW'(NUM_CREDITS);

  logic [CW-1:0] credits;
  logic          ready_int;
  logic          fire;
  logic [CW:0]   credits_next;

  // Ready comes from the credit register and the clear strobe only, so the
  // upstream never sees a combinational path from the link side.
  assign ready_int = (credits != '0) && !credit_clr;
  assign in.ready  = ready_int;
  assign fire      = in.valid && ready_int;

  // One extra bit lets an over-return be seen before it wraps. fire implies
  // credits >= 1, so the subtraction cannot underflow.
  always_comb begin
    credits_next = {1'b0, credits} - {{CW{1'b0}}, fire} + {1'b0, credit_incr};
  end

  // Credit counter, sticky error and output register. A clear wins over any
  // credit traffic and suppresses the outgoing beat; out_data is left holding
  // its last payload whenever no beat goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= FULL;
      credit_err <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (credit_clr) begin
      credits    <= FULL;
      credit_err <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= fire;
      if (fire) begin
        out_data <= in.data;
      end
      if (credits_next > FULL_EXT) begin
        credits    <= FULL;
        credit_err <= 1'b1;
      end else begin
        credits <= credits_next[CW-1:0];
      end
    end
  end

  assign credits_avail = credits;

`ifdef CREDIT_STREAM_TX_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] beat_q;

  // Saturating statistics; they restart together with the credit pool.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else if (credit_clr) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      if (in.valid && !ready_int && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (fire && (beat_q != 32'hFFFF_FFFF)) begin
        beat_q <= beat_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign beat_cnt  = beat_q;
`else
  assign stall_cnt = 32'd0;
  assign beat_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_credit_stream_tx.sv
// tb_credit_stream_tx: directed, self-checking bench for credit_stream_tx.
// Accepted beats are pushed to a scoreboard queue and popped when the DUT
// strobes out_valid; credits, error flag and statistics follow a small
// cycle model kept in the bench.
module tb_credit_stream_tx;

  typedef logic [7:0] data_t;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] credit_incr;
  logic          credit_clr;
  logic [CW-1:0] credits_avail;
  logic          credit_err;
  logic [31:0]   stall_cnt;
  logic [31:0]   beat_cnt;

  ready_valid_i #(.data_t(data_t)) in_if ();

  credit_stream_tx #(.data_t(data_t), .NUM_CREDITS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_if),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .credit_incr  (credit_incr),
    .credit_clr   (credit_clr),
    .credits_avail(credits_avail),
    .credit_err   (credit_err),
    .stall_cnt    (stall_cnt),
    .beat_cnt     (beat_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  data_t sb_q[$];
  data_t last_data;
  data_t next_data;
  int    m_credits;
  logic  m_err;
  int    m_stall;
  int    m_beat;
  int    pulse_cnt;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef CREDIT_STREAM_TX_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic resetModel();
    m_credits = N;
    m_err     = 1'b0;
    m_stall   = 0;
    m_beat    = 0;
    pulse_cnt = 0;
    last_data = '0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, predict it, then check after the edge.
  task automatic applyStimulus(input logic v, input logic [CW-1:0] incr, input logic clr,
                               input string tag);
    logic  exp_ready;
    logic  fire;
    int    nxt;
    data_t exp_d;
    in_if.valid = v;
    in_if.data  = next_data;
    credit_incr = incr;
    credit_clr  = clr;
    #1;
    exp_ready = (m_credits != 0) && !clr;
    checkOutput({tag, ".in_ready"}, 64'(in_if.ready), 64'(exp_ready));
    fire = v && exp_ready;
    if (fire) sb_q.push_back(next_data);
    if (clr) begin
      m_credits = N;
      m_err     = 1'b0;
      m_stall   = 0;
      m_beat    = 0;
      pulse_cnt = 0;
    end else begin
      nxt = m_credits - int'(fire) + int'(incr);
      if (nxt > N) begin
        m_credits = N;
        m_err     = 1'b1;
      end else begin
        m_credits = nxt;
      end
      if (v && !exp_ready) m_stall++;
      if (fire) m_beat++;
    end
    @(posedge clk);
    #1;
    if (fire) begin
      exp_d = sb_q.pop_front();
      last_data = exp_d;
      checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    end else begin
      checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    end
    checkOutput({tag, ".out_data"}, 64'(out_data), 64'(last_data));
    checkOutput({tag, ".credits_avail"}, 64'(credits_avail), 64'(m_credits));
    checkOutput({tag, ".credit_err"}, 64'(credit_err), 64'(m_err));
    checkOutput({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stat_exp(m_stall)));
    checkOutput({tag, ".beat_cnt"}, 64'(beat_cnt), 64'(stat_exp(m_beat)));
    if (out_valid === 1'b1) pulse_cnt++;
    next_data = next_data + 8'h07;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    credit_incr = '0;
    credit_clr  = 1'b0;
    next_data   = 8'h11;
    resetModel();

    // Reset state.
    #12;
    checkOutput("rst.out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst.out_data", 64'(out_data), 64'd0);
    checkOutput("rst.credits_avail", 64'(credits_avail), 64'(N));
    checkOutput("rst.credit_err", 64'(credit_err), 64'd0);
    checkOutput("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("rst.beat_cnt", 64'(beat_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaust all credits with valid held high, then two stalled cycles.
    for (int i = 0; i < N + 2; i++) applyStimulus(1'b1, '0, 1'b0, "drain");
    checkOutput("drain.credits_zero", 64'(credits_avail), 64'd0);

    // Return three credits while valid stays up: three more beats.
    applyStimulus(1'b1, CW'(3), 1'b0, "ret3");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, '0, 1'b0, "ret3.stream");

    // One credit, then fire and return in the same cycle: no bubble.
    applyStimulus(1'b0, CW'(1), 1'b0, "one");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, CW'(1), 1'b0, "net0");
    checkOutput("net0.credits_one", 64'(credits_avail), 64'd1);

    // Refill, over-return, sticky error, clear.
    applyStimulus(1'b0, '0, 1'b1, "clr");
    applyStimulus(1'b0, CW'(2), 1'b0, "ovf");
    applyStimulus(1'b0, '0, 1'b0, "ovf.sticky");
    applyStimulus(1'b1, CW'(1), 1'b0, "ovf.fire_ret");
    applyStimulus(1'b1, '0, 1'b1, "clr_err");
    checkOutput("clr_err.credit_err", 64'(credit_err), 64'd0);

    // Asynchronous reset between edges while a beat is on the output.
    applyStimulus(1'b0, CW'(2), 1'b0, "pre_rst.ovf");
    applyStimulus(1'b1, '0, 1'b0, "pre_rst.fire");
    in_if.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst.out_data", 64'(out_data), 64'd0);
    checkOutput("arst.credit_err", 64'(credit_err), 64'd0);
    checkOutput("arst.credits_avail", 64'(credits_avail), 64'(N));
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;

    // Statistics: clear, send N beats, then hold valid for 5 stalled cycles.
    applyStimulus(1'b0, '0, 1'b1, "stats.clr");
    for (int i = 0; i < N; i++) applyStimulus(1'b1, '0, 1'b0, "stats.beats");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, '0, 1'b0, "stats.stall");
    applyStimulus(1'b0, '0, 1'b0, "stats.idle");
`ifdef CREDIT_STREAM_TX_STATS_EN
    checkOutput("stats.stall_eq5", 64'(stall_cnt), 64'd5);
    checkOutput("stats.beat_eq_pulses", 64'(beat_cnt), 64'(pulse_cnt));
`else
    checkOutput("stats.stall_zero", 64'(stall_cnt), 64'd0);
    checkOutput("stats.beat_zero", 64'(beat_cnt), 64'd0);
`endif
    checkOutput("sb.empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
